// File: rtl/ipbb_fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ipbb_fifo_drain_pkg
//  Purpose  : Shared types and constants for the FIFO drain stage and its
//             statistics counter.
//  Contents : occ_t        - skid-buffer occupancy (0..2)
//             SKID_DEPTH   - number of skid-buffer entries
//             STAT_W_DFLT  - default statistics counter width
//  Revision : 1.0 - initial release
// ============================================================================
package ipbb_fifo_drain_pkg;

    typedef logic [1:0] occ_t;

    localparam int SKID_DEPTH  = 2;
    localparam int STAT_W_DFLT = 32;

endpackage : ipbb_fifo_drain_pkg
`default_nettype wire

// File: rtl/ipbb_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : ipbb_sat_cnt
//  Purpose  : Saturating up-counter with increment enable. Holds at all-ones
//             instead of wrapping. Used for the drain-stage statistics.
//  Config   : Only built when IPBB_FIFO_DRAIN_STATS_EN is defined (it has no
//             user otherwise).
//  Ports    : clk    in   clock
//             rst    in   asynchronous active-high reset (clears to 0)
//             inc_i  in   increment enable
//             cnt_o  out  current count, W bits
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef IPBB_FIFO_DRAIN_STATS_EN
module ipbb_sat_cnt
    import ipbb_fifo_drain_pkg::*;
#(
    parameter int W = STAT_W_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] C_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : ipbb_sat_cnt
`endif
`default_nettype wire

// File: rtl/ipbb_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module   : ipbb_fifo_drain
//  Purpose  : Pops words from a showahead FIFO head and presents them on a
//             valid/ready stream through a 2-entry skid buffer with
//             registered outputs. The FIFO read request depends only on
//             registered occupancy and the FIFO empty flag, never on o_ready.
//  Config   : IPBB_FIFO_DRAIN_STATS_EN - adds stat_beats / stat_stalls
//             saturating counters and their ports.
//  Ports    : clk           in   single clock
//             rst           in   asynchronous active-high reset
//             fifo_dout     in   showahead head word of upstream FIFO (DWD)
//             fifo_rdempty  in   upstream FIFO empty
//             fifo_rdreq    out  pop request to upstream FIFO (combinational)
//             o_valid       out  output word valid (registered)
//             o_data        out  output word (registered, DWD)
//             o_ready       in   downstream ready
//             stat_beats    out  accepted-beat count (macro only, STAT_W)
//             stat_stalls   out  stall-cycle count (macro only, STAT_W)
//  Revision : 1.0 - initial release
// ============================================================================
module ipbb_fifo_drain
    import ipbb_fifo_drain_pkg::*;
#(
    parameter int DWD    = 2,
    parameter int STAT_W = STAT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWD-1:0]    fifo_dout,
    input  logic              fifo_rdempty,
    output logic              fifo_rdreq,
    output logic              o_valid,
    output logic [DWD-1:0]    o_data,
    input  logic              o_ready
`ifdef IPBB_FIFO_DRAIN_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_beats,
    output logic [STAT_W-1:0] stat_stalls
`endif
);

    localparam occ_t C_OCC_EMPTY = 2'd0;
    localparam occ_t C_OCC_ONE   = 2'd1;
    localparam occ_t C_OCC_FULL  = occ_t'(SKID_DEPTH);

    if ((DWD < 1) || (STAT_W < 1)) begin : g_param_check
        $error("ipbb_fifo_drain: DWD and STAT_W must be at least 1");
    end

    occ_t           occ_q,   occ_d;
    logic           valid_q, valid_d;
    logic [DWD-1:0] head_q,  head_d;
    logic [DWD-1:0] spare_q, spare_d;

    logic           w_push;
    logic           w_pop;

    // Request only from registered occupancy and the FIFO flag so the
    // consumer's ready never reaches the FIFO read port combinationally.
    // Gated by rst so no pop is issued while the FIFO is being cleared.
    assign fifo_rdreq = !rst && !fifo_rdempty && (occ_q < C_OCC_FULL);

    assign w_push = fifo_rdreq;
    assign w_pop  = valid_q && o_ready;

    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        spare_d = spare_q;

        if (w_push && !w_pop) begin
            occ_d = occ_q + 2'd1;
            if (occ_q == C_OCC_EMPTY) begin
                head_d = fifo_dout;
            end else begin
                spare_d = fifo_dout;
            end
        end else if (w_pop && !w_push) begin
            occ_d = occ_q - 2'd1;
            // Spare is next in line; promote it so the stream never reorders.
            if (occ_q == C_OCC_FULL) begin
                head_d = spare_q;
            end
        end else if (w_push && w_pop) begin
            // Only reachable at occ=1 (no push at occ=2, no pop at occ=0):
            // the head leaves and the incoming word replaces it directly.
            if (occ_q == C_OCC_ONE) begin
                head_d = fifo_dout;
            end
        end

        // Valid is kept as its own flop so o_valid is a clean register output.
        valid_d = (occ_d != C_OCC_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= C_OCC_EMPTY;
            valid_q <= 1'b0;
            head_q  <= '0;
            spare_q <= '0;
        end else begin
            occ_q   <= occ_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            spare_q <= spare_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = head_q;

`ifdef IPBB_FIFO_DRAIN_STATS_EN
    logic w_stall;

    assign w_stall = valid_q && !o_ready;

    ipbb_sat_cnt #(
        .W (STAT_W)
    ) u_stat_beats (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_pop),
        .cnt_o (stat_beats)
    );

    ipbb_sat_cnt #(
        .W (STAT_W)
    ) u_stat_stalls (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_stall),
        .cnt_o (stat_stalls)
    );
`endif

endmodule : ipbb_fifo_drain
`default_nettype wire
